// File: rtl/mic1_pkg.sv
// Shared MIC-1 front-panel types and widths.
package mic1_pkg;
  localparam int unsigned MPC_W      = 9;
  localparam int unsigned STEP_CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_HALT
  } state_e;
endpackage

// File: rtl/mic1_step_clock_debounce.sv
// Two-flop synchronizer, stable-level debouncer and registered rising-edge pulse.
module debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) stable_d = sync2_q;
      else                                       cnt_d    = cnt_q + 1'b1;
    end
    rise_d = stable_q & ~stable_dly_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      rise_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= din;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      rise_q       <= rise_d;
      cnt_q        <= cnt_d;
    end
  end

  assign rise = rise_q;
endmodule

// File: rtl/mic1_step_clock.sv
// MIC-1 core clock generator: debounced single step, rate-selectable free run,
// MPC breakpoint halt and microcycle counter.
module mic1_step_clock
  import mic1_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned PULSE_CYCLES    = 4,
  parameter int unsigned RATE_UNIT       = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  step_btn,
  input  logic                  run_sw,
  input  logic [2:0]            rate_sel,
  input  logic                  bp_en,
  input  logic [MPC_W-1:0]      bp_addr,
  input  logic [MPC_W-1:0]      mpc,
  output logic                  cpu_clk,
  output logic                  running,
  output logic                  halted,
  output logic [STEP_CNT_W-1:0] step_count
);
  localparam int unsigned PH_W        = $clog2(PULSE_CYCLES + 1);
  localparam int unsigned MIN_IVL     = 2 * PULSE_CYCLES;
  localparam int unsigned IVL_W       = $clog2((RATE_UNIT << 7) + MIN_IVL + 1);
  localparam int unsigned RESET_LIMIT = (RATE_UNIT < MIN_IVL) ? MIN_IVL : RATE_UNIT;

  state_e                state_q, state_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic                  bp_arm_q, bp_arm_d;
  logic [STEP_CNT_W-1:0] step_count_q, step_count_d;
  logic                  cpu_clk_q, cpu_clk_d;
  logic                  run_s1_q, run_s2_q;
  logic [IVL_W-1:0]      ivl_cnt_q, ivl_cnt_d;
  logic [IVL_W-1:0]      limit_q, limit_d;
  logic [IVL_W-1:0]      nominal;
  logic                  step_req, run_req, ivl_en, last_phase, start, halted_c;

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk  (clock),
    .rst_n(reset),
    .din  (step_btn),
    .rise (step_req)
  );

  assign ivl_en     = run_s2_q && (state_q != ST_HALT);
  assign run_req    = ivl_en && (ivl_cnt_q == limit_q - 1'b1);
  assign last_phase = (phase_q == PH_W'(PULSE_CYCLES - 1));

  // Interval length is latched at each restart so a rate change never truncates a period.
  always_comb begin
    nominal   = IVL_W'(RATE_UNIT) << rate_sel;
    if (nominal < IVL_W'(MIN_IVL)) nominal = IVL_W'(MIN_IVL);
    ivl_cnt_d = ivl_cnt_q + 1'b1;
    limit_d   = limit_q;
    if (!ivl_en || run_req) begin
      ivl_cnt_d = '0;
      limit_d   = nominal;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      bp_arm_q     <= 1'b0;
      step_count_q <= '0;
      cpu_clk_q    <= 1'b0;
      run_s1_q     <= 1'b0;
      run_s2_q     <= 1'b0;
      ivl_cnt_q    <= '0;
      limit_q      <= IVL_W'(RESET_LIMIT);
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bp_arm_q     <= bp_arm_d;
      step_count_q <= step_count_d;
      cpu_clk_q    <= cpu_clk_d;
      run_s1_q     <= run_sw;
      run_s2_q     <= run_s1_q;
      ivl_cnt_q    <= ivl_cnt_d;
      limit_q      <= limit_d;
    end
  end

  // bp_arm marks pulses that may stop at the breakpoint: run ticks, and single steps
  // taken from HALT so the core stays parked while the MPC still matches.
  // A run tick landing on the last LOW clock chains straight into HIGH (50% duty at minimum).
  always_comb begin
    state_d  = state_q;
    phase_d  = '0;
    bp_arm_d = bp_arm_q;
    start    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (step_req || run_req) begin
          state_d  = ST_HIGH;
          bp_arm_d = run_req;
          start    = 1'b1;
        end
      end
      ST_HIGH: begin
        if (last_phase) state_d = ST_LOW;
        else            phase_d = phase_q + 1'b1;
      end
      ST_LOW: begin
        if (!last_phase) begin
          phase_d = phase_q + 1'b1;
        end else if (bp_arm_q && bp_en && (mpc == bp_addr)) begin
          state_d = ST_HALT;
        end else if (run_req) begin
          state_d  = ST_HIGH;
          bp_arm_d = 1'b1;
          start    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        if (!run_s2_q) begin
          state_d = ST_IDLE;
        end else if (step_req) begin
          state_d  = ST_HIGH;
          bp_arm_d = 1'b1;
          start    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    step_count_d = step_count_q + STEP_CNT_W'(start);
  end

  always_comb begin
    cpu_clk_d = (state_d == ST_HIGH);
    halted_c  = (state_q == ST_HALT);
  end

  assign cpu_clk    = cpu_clk_q;
  assign halted     = halted_c;
  assign running    = run_s2_q & ~halted_c;
  assign step_count = step_count_q;
endmodule

// File: tb/tb_mic1_step_clock.sv
// Directed/randomized bench for mic1_step_clock with an edge-timing reference model.
module tb_mic1_step_clock;
  localparam int unsigned DB    = 8;
  localparam int unsigned PULSE = 4;
  localparam int unsigned RU    = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        step_btn;
  logic        run_sw;
  logic [2:0]  rate_sel;
  logic        bp_en;
  logic [8:0]  bp_addr;
  logic [8:0]  mpc;
  logic        cpu_clk;
  logic        running;
  logic        halted;
  logic [31:0] step_count;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rises[$];
  int          highs[$];
  logic        prev_clk = 1'b0;
  int          hl = 0;
  logic [31:0] exp_steps = '0;

  mic1_step_clock #(
    .DEBOUNCE_CYCLES(DB),
    .PULSE_CYCLES   (PULSE),
    .RATE_UNIT      (RU)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .step_btn  (step_btn),
    .run_sw    (run_sw),
    .rate_sel  (rate_sel),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .mpc       (mpc),
    .cpu_clk   (cpu_clk),
    .running   (running),
    .halted    (halted),
    .step_count(step_count)
  );

  always #5 clock = ~clock;

  // Edge recorder: posedge index of every cpu_clk rise and length of every high phase.
  always @(posedge clock) begin
    #1;
    cyc++;
    if (cpu_clk && !prev_clk) begin
      rises.push_back(cyc);
      hl = 0;
    end
    if (cpu_clk) hl++;
    if (!cpu_clk && prev_clk) highs.push_back(hl);
    prev_clk = cpu_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic int last_high();
    return (highs.size() > 0) ? highs[highs.size()-1] : -1;
  endfunction

  // Random bounce, then a held press; the pulse must rise 2+DB+2 clocks after the
  // last 0->1 transition of the raw input.
  task automatic do_press(input string tag, input int nbounce);
    int   base, t0;
    logic v, prev;
    base = rises.size();
    prev = step_btn;
    t0   = cyc;
    for (int i = 0; i < nbounce + 20; i++) begin
      v = (i < nbounce) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v && !prev) t0 = cyc;
      step_btn = v;
      prev     = v;
      tick(1);
    end
    step_btn = 1'b0;
    tick(20);
    exp_steps++;
    chk({tag, "_pulses"}, rises.size() - base, 1);
    if (rises.size() > base) chk({tag, "_rise_time"}, rises[base], t0 + 2 + DB + 2);
    chk({tag, "_high_len"}, last_high(), PULSE);
    chk({tag, "_count"}, step_count, exp_steps);
  endtask

  initial begin
    int base, c0, r, n, bad, rs, per, t0;
    reset = 1'b0; step_btn = 1'b0; run_sw = 1'b0; rate_sel = '0;
    bp_en = 1'b0; bp_addr = '0; mpc = '0;

    tick(5);
    chk("in_reset_cpu_clk", cpu_clk, 0);
    reset = 1'b1;
    tick(50);
    chk("idle_cpu_clk", cpu_clk, 0);
    chk("idle_step_count", step_count, 0);
    chk("idle_running", running, 0);
    chk("idle_halted", halted, 0);

    for (int k = 0; k < 3; k++) do_press("press", $urandom_range(1, 3));

    base = rises.size();
    step_btn = 1'b1;
    tick(DB - 1);
    step_btn = 1'b0;
    tick(30);
    chk("short_press_ignored", rises.size() - base, 0);

    base = rises.size();
    t0 = cyc;
    step_btn = 1'b1;
    tick(DB);
    step_btn = 1'b0;
    tick(30);
    exp_steps++;
    chk("min_press_pulses", rises.size() - base, 1);
    if (rises.size() > base) chk("min_press_rise", rises[base], t0 + 2 + DB + 2);

    base = rises.size();
    rate_sel = 3'd1;
    c0 = cyc;
    run_sw = 1'b1;
    tick(200);
    n = rises.size() - base;
    chk("run_running", running, 1);
    chk("run_count_6_or_7", (n >= 6 && n <= 7), 1);
    if (n > 0) chk("run_first_rise", rises[base], c0 + 2 + 32);
    bad = 0;
    for (int i = base + 1; i < rises.size(); i++) if (rises[i] - rises[i-1] != 32) bad++;
    chk("run_gaps", bad, 0);
    n = rises.size();
    for (int i = 0; i < 40 && rises.size() == n; i++) tick(1);
    chk("run_wait_rise", rises.size(), n + 1);
    run_sw = 1'b0;
    n = rises.size();
    tick(40);
    chk("run_stop_full_pulse", last_high(), PULSE);
    chk("run_stop_no_more", rises.size(), n);
    chk("run_stop_running", running, 0);
    exp_steps += 32'(rises.size() - base);
    chk("run_step_count", step_count, exp_steps);

    for (int k = 0; k < 2; k++) begin
      rs = $urandom_range(0, 3);
      per = RU << rs;
      rate_sel = 3'(rs);
      tick(3);
      base = rises.size();
      run_sw = 1'b1;
      for (int i = 0; i < 6 * per + 50 && rises.size() < base + 4; i++) tick(1);
      run_sw = 1'b0;
      tick(20);
      chk("rate_wait", rises.size() >= base + 4, 1);
      bad = 0;
      if (rises.size() >= base + 4)
        for (int i = base + 1; i < base + 4; i++) if (rises[i] - rises[i-1] != per) bad++;
      chk("rate_gaps", bad, 0);
      exp_steps += 32'(rises.size() - base);
      chk("rate_step_count", step_count, exp_steps);
    end

    bp_en = 1'b1;
    bp_addr = 9'h00A;
    mpc = 9'($urandom_range(0, 511));
    if (mpc == 9'h00A) mpc = 9'h00B;
    rate_sel = 3'd0;
    tick(3);
    base = rises.size();
    run_sw = 1'b1;
    for (int i = 0; i < 200 && rises.size() < base + 3; i++) tick(1);
    chk("bp_wait_3", rises.size(), base + 3);
    r = (rises.size() >= base + 3) ? rises[base+2] : cyc;
    mpc = 9'h00A;
    while (cyc < r + 2 * PULSE - 1) tick(1);
    chk("bp_not_yet_halted", halted, 0);
    tick(1);
    chk("bp_halted", halted, 1);
    chk("bp_not_running", running, 0);
    tick(100);
    chk("bp_no_more_pulses", rises.size(), base + 3);
    exp_steps += 3;
    chk("bp_step_count", step_count, exp_steps);

    do_press("halt_step", 2);
    chk("halt_step_still_halted", halted, 1);
    run_sw = 1'b0;
    tick(4);
    chk("halt_exit_on_run_off", halted, 0);
    mpc = 9'h00B;

    force dut.step_count_q = 32'hFFFF_FFFF;
    tick(1);
    release dut.step_count_q;
    tick(1);
    chk("preload", step_count, 32'hFFFF_FFFF);
    exp_steps = 32'hFFFF_FFFF;
    do_press("wrap", 1);

    base = rises.size();
    step_btn = 1'b1;
    for (int i = 0; i < 40 && rises.size() == base; i++) tick(1);
    chk("rst_pre_high", cpu_clk, 1);
    reset = 1'b0;
    step_btn = 1'b0;
    #1;
    chk("rst_async_clk_low", cpu_clk, 0);
    chk("rst_count_zero", step_count, 0);
    tick(5);
    reset = 1'b1;
    tick(20);
    exp_steps = '0;
    do_press("post_reset", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
